omsp_bcd_serial_alu: RTL and testbench

Parametrised, digit-serial packed-BCD adder/subtractor for the openMSP430 execution unit. It is the multi-digit successor of the single-nibble decimal-adjust datapath in `omsp_alu`. It processes `DPC` BCD digits per clock, supports add and subtract with carry/borrow, and flags non-BCD input digits. A start/done handshake lets the frontend stall while a long decimal operation (`DADD.W` or wider) completes.

---
 rtl/omsp_bcd_serial_alu.sv | 147 ++++++++++++++
 tb/tb_omsp_bcd_serial_alu.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_bcd_serial_alu.sv
// rtl/omsp_bcd_serial_alu.sv - digit-serial packed-BCD adder/subtractor with start/done handshake
module omsp_bcd_serial_alu #(
  parameter int DIGITS = 4,
  parameter int DPC    = 1
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                start,
  input  logic                sub,
  input  logic                carry_in,
  input  logic [4*DIGITS-1:0] op_a,
  input  logic [4*DIGITS-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry_out,
  output logic                zero,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int GW = 4 * DPC;
  localparam int N  = DIGITS / DPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DPC < 1 || (DIGITS % DPC) != 0) begin : g_bad_dpc
      $error("omsp_bcd_serial_alu: DPC must divide DIGITS exactly");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, work_q, work_nxt;
  logic [GW-1:0]   grp;
  logic [CW-1:0]   cnt;
  logic            sub_q, c_q, c_nxt, inv_q, inv_in;
  logic            accept, last;

  // A new operation is only accepted outside RUN so a stray start cannot disturb the working registers
  assign accept = start && (state != S_RUN);
  assign last   = (state == S_RUN) && (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge mclk) begin
    if (puc_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and handshake outputs; DONE chains straight into RUN on a held start
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One group of DPC digit adders chained through the decimal carry, least-significant digit first
  always_comb begin
    logic       c;
    logic [3:0] ad, bd, bp;
    logic [4:0] s;
    c   = c_q;
    grp = '0;
    ad  = '0;
    bd  = '0;
    bp  = '0;
    s   = '0;
    for (int i = 0; i < DPC; i++) begin
      ad = a_q[4*i +: 4];
      bd = b_q[4*i +: 4];
      // Nine's complement of the subtrahend digit, wrapping for non-BCD digits
      bp = sub_q ? (4'd9 - bd) : bd;
      s  = {1'b0, ad} + {1'b0, bp} + {4'd0, c};
      if (s >= 5'd10) begin
        grp[4*i +: 4] = 4'(s - 5'd10);
        c             = 1'b1;
      end else begin
        grp[4*i +: 4] = s[3:0];
        c             = 1'b0;
      end
    end
    c_nxt = c;
  end

  // Finished digits enter at the top so after N groups the least-significant digit sits in bits [3:0]
  assign work_nxt = (work_q >> GW) | (W'(grp) << (W - GW));

  // Flag any operand digit above 9 at the moment the operands are captured
  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9) inv_in = 1'b1;
    end
  end

  // Working registers and result capture on the final RUN cycle
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      sub_q     <= 1'b0;
      c_q       <= 1'b0;
      inv_q     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      invalid   <= 1'b0;
    end else if (accept) begin
      a_q    <= op_a;
      b_q    <= op_b;
      sub_q  <= sub;
      // Subtraction runs as a + (nines complement of b) + 1, so an incoming borrow clears that +1
      c_q    <= sub ? ~carry_in : carry_in;
      inv_q  <= inv_in;
      work_q <= '0;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      a_q    <= a_q >> GW;
      b_q    <= b_q >> GW;
      c_q    <= c_nxt;
      work_q <= work_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        result    <= work_nxt;
        zero      <= (work_nxt == '0);
        carry_out <= sub_q ? ~c_nxt : c_nxt;
        invalid   <= inv_q;
      end
    end
  end

endmodule

// File: tb/tb_omsp_bcd_serial_alu.sv
// tb/tb_omsp_bcd_serial_alu.sv - self-checking bench for omsp_bcd_serial_alu (4x1 and 8x2 instances)
module tb_omsp_bcd_serial_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, co4, z4, inv4;
  logic [15:0] res4;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [31:0] a8 = '0, b8 = '0;
  logic        busy8, done8, co8, z8, inv8;
  logic [31:0] res8;

  omsp_bcd_serial_alu #(.DIGITS(4), .DPC(1)) u_dut4 (
    .mclk(clk), .puc_rst(rst), .start(start4), .sub(sub4), .carry_in(cin4),
    .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .result(res4),
    .carry_out(co4), .zero(z4), .invalid(inv4)
  );

  omsp_bcd_serial_alu #(.DIGITS(8), .DPC(2)) u_dut8 (
    .mclk(clk), .puc_rst(rst), .start(start8), .sub(sub8), .carry_in(cin8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .result(res8),
    .carry_out(co8), .zero(z8), .invalid(inv8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint bcd2int(input logic [31:0] v, input int nd);
    longint r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint t, input int nd);
    logic [31:0] r = '0;
    longint      x = t;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Valid operands use plain decimal arithmetic; non-BCD digits follow the digit rule directly
  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                           input int nd, output logic [31:0] r, output logic co,
                           output logic z, output logic inv);
    longint     lim, t;
    logic       cc;
    logic [3:0] bp;
    logic [4:0] sm;
    inv = 1'b0;
    r   = '0;
    co  = 1'b0;
    for (int i = 0; i < nd; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) inv = 1'b1;
    lim = pow10(nd);
    if (!inv) begin
      if (!s) begin
        t  = bcd2int(a, nd) + bcd2int(b, nd) + longint'(c);
        co = (t >= lim);
        if (t >= lim) t = t - lim;
      end else begin
        t  = bcd2int(a, nd) - bcd2int(b, nd) - longint'(c);
        co = (t < 0);
        if (t < 0) t = t + lim;
      end
      r = int2bcd(t, nd);
    end else begin
      cc = s ? ~c : c;
      for (int i = 0; i < nd; i++) begin
        bp = s ? 4'(4'd9 - b[4*i +: 4]) : b[4*i +: 4];
        sm = 5'(a[4*i +: 4]) + 5'(bp) + 5'(cc);
        if (sm >= 5'd10) begin r[4*i +: 4] = 4'(sm - 5'd10); cc = 1'b1; end
        else begin r[4*i +: 4] = sm[3:0]; cc = 1'b0; end
      end
      co = s ? ~cc : cc;
    end
    z = (r == '0);
  endtask

  function automatic logic [31:0] gen_operand(input int nd);
    logic [31:0] v;
    int          d;
    v = int2bcd(longint'($urandom_range(0, 32'(pow10(nd) - 1))), nd);
    if ($urandom_range(0, 5) == 0) begin
      d = int'($urandom_range(0, nd - 1));
      v[4*d +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                     output int edges, output int busy_cyc);
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4   = 1'b0;
    edges    = 1;
    busy_cyc = 0;
    while (!done4 && edges < 40) begin
      if (busy4) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                     output int edges);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges  = 1;
    while (!done8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        s, c;
    logic [15:0] r;
    logic        co, z, inv;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          e, bc, nd;
    logic [31:0] ra, rb, er;
    logic        rs, rc, eco, ez, einv;
    logic [15:0] got;
    logic        ginv;

    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h0500, 16'h0250, 1'b1, 1'b1, 16'h0249, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_res4", res4, 0);
    chk("rst_co4", co4, 0);
    chk("rst_z4", z4, 0);
    chk("rst_inv4", inv4, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_res8", res8, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      op4(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, e, bc);
      chk($sformatf("vec%0d_edges", i), e, 5);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 4);
      chk($sformatf("vec%0d_res", i), res4, tbl[i].r);
      chk($sformatf("vec%0d_co", i), co4, tbl[i].co);
      chk($sformatf("vec%0d_zero", i), z4, tbl[i].z);
      chk($sformatf("vec%0d_inv", i), inv4, tbl[i].inv);
    end

    // start pulsed mid-RUN with different operands must be ignored
    @(negedge clk);
    a4 = 16'h00A0; b4 = 16'h0000; sub4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 16'h5555; b4 = 16'h4444; sub4 = 1'b1;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    e = 0; got = '0; ginv = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done4) begin e++; got = res4; ginv = inv4; end
    end
    chk("midrun_done_count", e, 1);
    chk("midrun_res", got, 16'h0100);
    chk("midrun_inv", ginv, 1);

    // reset on the second RUN cycle aborts the operation
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h5678; sub4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    chk("abort_res", res4, 0);
    chk("abort_co", co4, 0);
    chk("abort_zero", z4, 0);
    chk("abort_inv", inv4, 0);
    e = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done4 || busy4) e++;
    end
    chk("abort_no_activity", e, 0);
    op4(16'h1234, 16'h5678, 1'b0, 1'b0, e, bc);
    chk("after_abort_edges", e, 5);
    chk("after_abort_res", res4, 16'h6912);

    // 8-digit, 2 digits per cycle
    op8(32'h12345678, 32'h87654322, 1'b0, 1'b0, e);
    chk("w8_edges", e, 5);
    chk("w8_res", res8, 32'h00000000);
    chk("w8_co", co8, 1);
    chk("w8_zero", z8, 1);

    // back-to-back: start held through DONE re-enters RUN without an IDLE cycle
    @(negedge clk);
    a8 = 32'h50000000; b8 = 32'h50000000; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    e = 1;
    while (!done8 && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    chk("b2b_first_edges", e, 5);
    chk("b2b_first_res", res8, 32'h00000000);
    chk("b2b_first_co", co8, 1);
    a8 = 32'h00000000; b8 = 32'h00000001; sub8 = 1'b1; cin8 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_reenter_busy", busy8, 1);
    chk("b2b_reenter_done", done8, 0);
    start8 = 1'b0;
    e = 1;
    while (!done8 && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    chk("b2b_second_edges", e, 5);
    chk("b2b_second_res", res8, 32'h99999999);
    chk("b2b_second_co", co8, 1);

    // randomized operations against the reference model
    for (int it = 0; it < 60; it++) begin
      nd = (it < 40) ? 4 : 8;
      ra = gen_operand(nd);
      rb = gen_operand(nd);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rs, rc, nd, er, eco, ez, einv);
      if (nd == 4) begin
        op4(ra[15:0], rb[15:0], rs, rc, e, bc);
        chk($sformatf("rnd%0d_edges", it), e, 5);
        chk($sformatf("rnd%0d_res", it), res4, er[15:0]);
        chk($sformatf("rnd%0d_co", it), co4, eco);
        chk($sformatf("rnd%0d_zero", it), z4, ez);
        chk($sformatf("rnd%0d_inv", it), inv4, einv);
      end else begin
        op8(ra, rb, rs, rc, e);
        chk($sformatf("rnd%0d_edges", it), e, 5);
        chk($sformatf("rnd%0d_res", it), res8, er);
        chk($sformatf("rnd%0d_co", it), co8, eco);
        chk($sformatf("rnd%0d_zero", it), z8, ez);
        chk($sformatf("rnd%0d_inv", it), inv8, einv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
